// File: rtl/pc_control.sv
// rtl/pc_control.sv - next-PC select with condition decode and registered PC
module pc_control (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        en,
  input  logic [2:0]  C,
  input  logic [8:0]  I,
  input  logic [2:0]  F,
  input  logic [15:0] PC_in,
  input  logic [15:0] BR,
  output logic [15:0] PC_out,
  output logic        taken,
  output logic [15:0] PC_q
);

  typedef enum logic [2:0] {
    CC_NE = 3'b000,
    CC_EQ = 3'b001,
    CC_GT = 3'b010,
    CC_LT = 3'b011,
    CC_GE = 3'b100,
    CC_LE = 3'b101,
    CC_OV = 3'b110,
    CC_UN = 3'b111
  } cond_e;

  logic        flag_z;
  logic        flag_v;
  logic        flag_n;
  logic [15:0] seq_pc;
  logic [15:0] off;
  logic [15:0] PC_d;

  assign flag_z = F[2];
  assign flag_v = F[1];
  assign flag_n = F[0];
  assign seq_pc = PC_in + 16'd2;
  // word offset: sign-extend then convert to bytes
  assign off    = {{6{I[8]}}, I, 1'b0};

  always_comb begin
    taken = 1'b0;
    unique case (cond_e'(C))
      CC_NE:   taken = ~flag_z;
      CC_EQ:   taken = flag_z;
      CC_GT:   taken = ~flag_z & ~flag_n;
      CC_LT:   taken = flag_n;
      CC_GE:   taken = flag_z | ~flag_n;
      CC_LE:   taken = flag_n | flag_z;
      CC_OV:   taken = flag_v;
      CC_UN:   taken = 1'b1;
      default: taken = 1'b0;
    endcase
  end

  always_comb begin
    PC_out = seq_pc;
    if (taken) begin
      PC_out = BR[0] ? (seq_pc + off) : BR;
    end
  end

  always_comb begin
    PC_d = PC_q;
    if (en) begin
      PC_d = PC_out;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      PC_q <= 16'h0000;
    end else begin
      PC_q <= PC_d;
    end
  end

endmodule

// File: tb/tb_pc_control.sv
// tb/tb_pc_control.sv - vector, sweep, random and register checks for pc_control
module tb_pc_control;

  logic        clk;
  logic        rst_n;
  logic        en;
  logic [2:0]  C;
  logic [8:0]  I;
  logic [2:0]  F;
  logic [15:0] PC_in;
  logic [15:0] BR;
  logic [15:0] PC_out;
  logic        taken;
  logic [15:0] PC_q;

  int total = 0;
  int bad   = 0;

  pc_control dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .en     (en),
    .C      (C),
    .I      (I),
    .F      (F),
    .PC_in  (PC_in),
    .BR     (BR),
    .PC_out (PC_out),
    .taken  (taken),
    .PC_q   (PC_q)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  c;
    logic [8:0]  i;
    logic [2:0]  f;
    logic [15:0] pc;
    logic [15:0] br;
    logic        exp_taken;
    logic [15:0] exp_pc;
  } vec_t;

  vec_t vecs[$];

  function automatic logic model_taken(input logic [2:0] c, input logic [2:0] f);
    bit z, v, n;
    z = f[2];
    v = f[1];
    n = f[0];
    case (c)
      3'd0: return !z;
      3'd1: return z;
      3'd2: return !z && !n;
      3'd3: return n;
      3'd4: return z || !n;
      3'd5: return n || z;
      3'd6: return v;
      default: return 1'b1;
    endcase
  endfunction

  function automatic logic [15:0] model_pc(input logic [2:0] c, input logic [8:0] i,
                                           input logic [2:0] f, input logic [15:0] pc,
                                           input logic [15:0] br);
    int target;
    int words;
    words = int'(i);
    if (words >= 256) words = words - 512;
    if (!model_taken(c, f))      target = int'(pc) + 2;
    else if (br[0])              target = int'(pc) + 2 + 2 * words;
    else                         target = int'(br);
    target = target % 65536;
    if (target < 0) target = target + 65536;
    return target[15:0];
  endfunction

  task automatic check16(input string name, input logic [15:0] act, input logic [15:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", name, act, exp);
    end
  endtask

  task automatic apply(input logic [2:0] c, input logic [8:0] i, input logic [2:0] f,
                       input logic [15:0] pc, input logic [15:0] br);
    C = c; I = i; F = f; PC_in = pc; BR = br;
    #1;
  endtask

  initial begin
    logic [15:0] exp_q;
    logic [15:0] exp_next;

    rst_n = 1'b0; en = 1'b0;
    C = 3'd0; I = 9'd0; F = 3'd0; PC_in = 16'd0; BR = 16'd0;

    // hand-derived vectors
    vecs.push_back('{3'd2, 9'h004, 3'd0, 16'h0000, 16'hFFFF, 1'b1, 16'h000A});
    vecs.push_back('{3'd2, 9'h004, 3'd1, 16'h0000, 16'hFFFF, 1'b0, 16'h0002});
    vecs.push_back('{3'd7, 9'h1FF, 3'd0, 16'h0010, 16'h0001, 1'b1, 16'h0010});
    vecs.push_back('{3'd0, 9'h000, 3'd4, 16'hFFFE, 16'h0001, 1'b0, 16'h0000});
    vecs.push_back('{3'd7, 9'h100, 3'd0, 16'h0000, 16'h0001, 1'b1, 16'hFE02});
    vecs.push_back('{3'd4, 9'h004, 3'd0, 16'h0000, 16'hFFFF, 1'b1, 16'h000A});
    vecs.push_back('{3'd4, 9'h004, 3'd1, 16'h0000, 16'hFFFF, 1'b0, 16'h0002});
    vecs.push_back('{3'd4, 9'h004, 3'd4, 16'h0000, 16'hFFFF, 1'b1, 16'h000A});
    vecs.push_back('{3'd5, 9'h004, 3'd0, 16'h0000, 16'hFFFF, 1'b0, 16'h0002});
    vecs.push_back('{3'd5, 9'h004, 3'd1, 16'h0000, 16'hFFFF, 1'b1, 16'h000A});
    vecs.push_back('{3'd6, 9'h004, 3'd2, 16'h0000, 16'hFF00, 1'b1, 16'hFF00});
    vecs.push_back('{3'd7, 9'h0FF, 3'd0, 16'hFF00, 16'h0003, 1'b1, 16'h0100});

    #2;
    check16("reset_pc_q", PC_q, 16'h0000);

    // combinational checks while in reset: outputs must still track inputs
    foreach (vecs[k]) begin
      apply(vecs[k].c, vecs[k].i, vecs[k].f, vecs[k].pc, vecs[k].br);
      check16($sformatf("vec%0d_taken", k), {15'd0, taken}, {15'd0, vecs[k].exp_taken});
      check16($sformatf("vec%0d_pc", k), PC_out, vecs[k].exp_pc);
    end

    for (int c = 0; c < 8; c++) begin
      for (int f = 0; f < 8; f++) begin
        apply(c[2:0], 9'h004, f[2:0], 16'h0000, 16'hFFFF);
        check16($sformatf("sweepB_c%0d_f%0d_taken", c, f), {15'd0, taken},
                {15'd0, model_taken(c[2:0], f[2:0])});
        check16($sformatf("sweepB_c%0d_f%0d_pc", c, f), PC_out,
                model_taken(c[2:0], f[2:0]) ? 16'h000A : 16'h0002);
        apply(c[2:0], 9'h004, f[2:0], 16'h0000, 16'hFF00);
        check16($sformatf("sweepR_c%0d_f%0d_pc", c, f), PC_out,
                model_taken(c[2:0], f[2:0]) ? 16'hFF00 : 16'h0002);
      end
    end

    for (int r = 0; r < 300; r++) begin
      apply(3'($urandom), 9'($urandom), 3'($urandom), 16'($urandom), 16'($urandom));
      check16($sformatf("rand%0d_taken", r), {15'd0, taken}, {15'd0, model_taken(C, F)});
      check16($sformatf("rand%0d_pc", r), PC_out, model_pc(C, I, F, PC_in, BR));
    end
    check16("reset_hold_pc_q", PC_q, 16'h0000);

    // register capture after reset release
    @(negedge clk);
    rst_n = 1'b1; en = 1'b1;
    apply(3'd7, 9'h000, 3'd0, 16'h0000, 16'h1234);
    @(posedge clk); #1;
    check16("capture_1234", PC_q, 16'h1234);

    @(negedge clk);
    en = 1'b0;
    for (int h = 0; h < 4; h++) begin
      apply(3'($urandom), 9'($urandom), 3'($urandom), 16'($urandom), 16'($urandom));
      @(posedge clk); #1;
      check16($sformatf("hold%0d", h), PC_q, 16'h1234);
      @(negedge clk);
    end

    exp_q = 16'h1234;
    for (int r = 0; r < 100; r++) begin
      en = 1'($urandom);
      apply(3'($urandom), 9'($urandom), 3'($urandom), 16'($urandom), 16'($urandom));
      exp_next = model_pc(C, I, F, PC_in, BR);
      if (en) exp_q = exp_next;
      @(posedge clk); #1;
      check16($sformatf("reg%0d", r), PC_q, exp_q);
      @(negedge clk);
    end

    // async reset between edges
    en = 1'b1;
    apply(3'd7, 9'h000, 3'd0, 16'h0000, 16'h1234);
    @(posedge clk); #1;
    check16("pre_async_1234", PC_q, 16'h1234);
    #2;
    rst_n = 1'b0;
    #1;
    check16("async_reset_pc_q", PC_q, 16'h0000);
    check16("async_reset_pc_out", PC_out, 16'h1234);
    apply(3'd0, 9'h000, 3'd4, 16'hFFFE, 16'h0001);
    check16("reset_pc_out_tracks", PC_out, 16'h0000);
    @(posedge clk); #1;
    check16("reset_blocks_capture", PC_q, 16'h0000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
